// File: rtl/verificador_cuenta_pkg.sv
// ---------------------------------------------------------------------------
// verificador_pkg
// Shared definitions for the counter sequence checker:
//   - ANCHO_ESTADO : width of the FSM state code seen on o_estado
//   - estado_e     : FSM state codes (INICIO / BUSCANDO / SINCRONIZADO)
//   - clase_e      : classification of an accepted value against the reference
// ---------------------------------------------------------------------------
package verificador_pkg;

  localparam int ANCHO_ESTADO = 2;

  typedef enum logic [ANCHO_ESTADO-1:0] {
    INICIO       = 2'd0,
    BUSCANDO     = 2'd1,
    SINCRONIZADO = 2'd2,
    NO_USADO     = 2'd3
  } estado_e;

  // Result of comparing an accepted value with the stored reference.
  typedef enum logic [1:0] {
    CLASE_IGUAL    = 2'd0,
    CLASE_CORRECTO = 2'd1,
    CLASE_ERRONEO  = 2'd2
  } clase_e;

endpackage

// File: rtl/verificador_cuenta_if.sv
// ---------------------------------------------------------------------------
// verificador_cuenta_if
// Bundles the observed count, the sampling enable and all checker status
// outputs.
//   master : the side that drives the count (counter / bench / board logic)
//   slave  : the checker itself
// Signals:
//   i_cuenta       [ANCHO]     count under observation (asynchronous source)
//   i_habilitar    [1]         sampling enable
//   o_sincronizado [1]         high while locked
//   o_error        [1]         one-cycle pulse on a sequencing error while locked
//   o_errores      [ANCHO_ERR] saturating error count
//   o_vueltas      [ANCHO_ERR] saturating wrap count
//   o_estado       [2]         current FSM state
// ---------------------------------------------------------------------------
interface verificador_cuenta_if #(
  parameter int ANCHO     = 4,
  parameter int ANCHO_ERR = 8
);

  logic [ANCHO-1:0]     i_cuenta;
  logic                 i_habilitar;
  logic                 o_sincronizado;
  logic                 o_error;
  logic [ANCHO_ERR-1:0] o_errores;
  logic [ANCHO_ERR-1:0] o_vueltas;
  logic [1:0]           o_estado;

  modport master (
    output i_cuenta,
    output i_habilitar,
    input  o_sincronizado,
    input  o_error,
    input  o_errores,
    input  o_vueltas,
    input  o_estado
  );

  modport slave (
    input  i_cuenta,
    input  i_habilitar,
    output o_sincronizado,
    output o_error,
    output o_errores,
    output o_vueltas,
    output o_estado
  );

endinterface

// File: rtl/verificador_cuenta_filtro.sv
// ---------------------------------------------------------------------------
// filtro_estable
// Brings the asynchronous count into the i_clk domain through a 2-flop
// synchronizer, then accepts a value only after ESTABLE consecutive identical
// enabled samples.
// Ports:
//   i_clk       checker clock
//   i_rst       asynchronous active-high reset
//   i_cuenta    raw count (asynchronous)
//   i_habilitar sampling enable; low clears the stability counter
//   o_valor     synchronized sample being evaluated on this edge
//   o_aceptado  combinational strobe: the edge that ends this cycle accepts
//               o_valor (fires once per candidate)
// ---------------------------------------------------------------------------
module filtro_estable #(
  parameter int ANCHO   = 4,
  parameter int ESTABLE = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [ANCHO-1:0] i_cuenta,
  input  logic             i_habilitar,
  output logic [ANCHO-1:0] o_valor,
  output logic             o_aceptado
);

  localparam int                   ANCHO_EST = $clog2(ESTABLE + 1);
  localparam logic [ANCHO_EST-1:0] EST_MAX   = ANCHO_EST'(ESTABLE);
  localparam logic [ANCHO_EST-1:0] EST_UNO   = ANCHO_EST'(1);

  logic [ANCHO-1:0]     sinc1_q;
  logic [ANCHO-1:0]     sinc2_q;
  logic [ANCHO-1:0]     cand_q;
  logic [ANCHO-1:0]     cand_d;
  logic [ANCHO_EST-1:0] estab_q;
  logic [ANCHO_EST-1:0] estab_d;
  logic                 aceptado;

  // The synchronizer keeps running while sampling is disabled so that a
  // re-enable never evaluates a stale, half-settled value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sinc1_q <= '0;
      sinc2_q <= '0;
      cand_q  <= '0;
      estab_q <= '0;
    end else begin
      sinc1_q <= i_cuenta;
      sinc2_q <= sinc1_q;
      cand_q  <= cand_d;
      estab_q <= estab_d;
    end
  end

  always_comb begin
    cand_d   = cand_q;
    estab_d  = estab_q;
    aceptado = 1'b0;
    if (!i_habilitar) begin
      // Only the stability count is dropped; the candidate value stays, so a
      // re-enabled value still needs ESTABLE fresh samples.
      estab_d = '0;
    end else if (sinc2_q == cand_q) begin
      // Saturated means already accepted: no second strobe for this candidate.
      if (estab_q != EST_MAX) begin
        estab_d  = estab_q + EST_UNO;
        aceptado = (estab_d == EST_MAX);
      end
    end else begin
      cand_d   = sinc2_q;
      estab_d  = EST_UNO;
      aceptado = (ESTABLE == 1);
    end
  end

  assign o_valor    = sinc2_q;
  assign o_aceptado = aceptado;

endmodule

// File: rtl/verificador_cuenta.sv
// ---------------------------------------------------------------------------
// verificador_cuenta
// Sequence checker for an ANCHO-bit up-counter. Filtered values are compared
// with the last accepted one: +1 (mod 2^ANCHO) is correct, equal is ignored,
// anything else is wrong. N_BLOQUEO consecutive correct steps lock the
// checker; a wrong step while locked pulses o_error, bumps o_errores and
// drops back to searching. Wraps (max -> 0) while locked bump o_vueltas.
// Ports:
//   i_clk  checker clock
//   i_rst  asynchronous active-high reset
//   bus    verificador_cuenta_if.slave (count in, status out)
// ---------------------------------------------------------------------------
module verificador_cuenta
  import verificador_pkg::*;
#(
  parameter int ANCHO     = 4,
  parameter int ESTABLE   = 2,
  parameter int N_BLOQUEO = 3,
  parameter int ANCHO_ERR = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  verificador_cuenta_if.slave  bus
);

  localparam int                   ANCHO_RUN = $clog2(N_BLOQUEO + 1);
  localparam logic [ANCHO_RUN-1:0] RUN_META  = ANCHO_RUN'(N_BLOQUEO);
  localparam logic [ANCHO_RUN-1:0] RUN_UNO   = ANCHO_RUN'(1);
  localparam logic [ANCHO-1:0]     CNT_UNO   = ANCHO'(1);
  localparam logic [ANCHO_ERR-1:0] ERR_UNO   = ANCHO_ERR'(1);

  logic [ANCHO-1:0]     valor;
  logic                 aceptado;

  estado_e              estado_q;
  estado_e              estado_d;
  logic [ANCHO-1:0]     ref_q;
  logic [ANCHO-1:0]     ref_d;
  logic [ANCHO_RUN-1:0] corrida_q;
  logic [ANCHO_RUN-1:0] corrida_d;
  logic [ANCHO_ERR-1:0] errores_q;
  logic [ANCHO_ERR-1:0] errores_d;
  logic [ANCHO_ERR-1:0] vueltas_q;
  logic [ANCHO_ERR-1:0] vueltas_d;
  logic                 error_q;
  logic                 error_d;
  logic                 sinc_q;
  logic                 sinc_d;

  logic [ANCHO-1:0]     ref_mas_uno;
  logic [ANCHO_RUN-1:0] corrida_mas_uno;
  clase_e               clase;
  logic                 es_vuelta;

  filtro_estable #(
    .ANCHO   (ANCHO),
    .ESTABLE (ESTABLE)
  ) u_filtro (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_cuenta    (bus.i_cuenta),
    .i_habilitar (bus.i_habilitar),
    .o_valor     (valor),
    .o_aceptado  (aceptado)
  );

  // Classification of the value accepted on this edge. The +1 naturally
  // wraps at ANCHO bits, which gives the modulo 2^ANCHO step.
  always_comb begin
    ref_mas_uno = ref_q + CNT_UNO;
    es_vuelta   = (ref_q == '1) && (valor == '0);
    if (valor == ref_q) begin
      clase = CLASE_IGUAL;
    end else if (valor == ref_mas_uno) begin
      clase = CLASE_CORRECTO;
    end else begin
      clase = CLASE_ERRONEO;
    end
  end

  assign corrida_mas_uno = corrida_q + RUN_UNO;

  // State register (all flops of the top level).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      estado_q  <= INICIO;
      ref_q     <= '0;
      corrida_q <= '0;
      errores_q <= '0;
      vueltas_q <= '0;
      error_q   <= 1'b0;
      sinc_q    <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      ref_q     <= ref_d;
      corrida_q <= corrida_d;
      errores_q <= errores_d;
      vueltas_q <= vueltas_d;
      error_q   <= error_d;
      sinc_q    <= sinc_d;
    end
  end

  // Next-state logic.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIO: begin
        if (aceptado) begin
          estado_d = BUSCANDO;
        end
      end
      BUSCANDO: begin
        if (aceptado && (clase == CLASE_CORRECTO) && (corrida_mas_uno == RUN_META)) begin
          estado_d = SINCRONIZADO;
        end
      end
      SINCRONIZADO: begin
        if (aceptado && (clase == CLASE_ERRONEO)) begin
          estado_d = BUSCANDO;
        end
      end
      default: begin
        // Unused encoding recovers without waiting for an acceptance.
        estado_d = INICIO;
      end
    endcase
  end

  // Output / datapath logic. Every output is the registered form of these
  // next values, so status changes on the same edge as the acceptance.
  always_comb begin
    ref_d     = ref_q;
    corrida_d = corrida_q;
    errores_d = errores_q;
    vueltas_d = vueltas_q;
    error_d   = 1'b0;
    if (aceptado) begin
      case (estado_q)
        INICIO: begin
          ref_d     = valor;
          corrida_d = '0;
        end
        BUSCANDO: begin
          ref_d = valor;
          if (clase == CLASE_CORRECTO) begin
            corrida_d = corrida_mas_uno;
          end else if (clase == CLASE_ERRONEO) begin
            corrida_d = '0;
          end
        end
        SINCRONIZADO: begin
          ref_d = valor;
          if (clase == CLASE_CORRECTO) begin
            if (es_vuelta && (vueltas_q != '1)) begin
              vueltas_d = vueltas_q + ERR_UNO;
            end
          end else if (clase == CLASE_ERRONEO) begin
            error_d   = 1'b1;
            corrida_d = '0;
            if (errores_q != '1) begin
              errores_d = errores_q + ERR_UNO;
            end
          end
        end
        default: begin
          ref_d = ref_q;
        end
      endcase
    end
    sinc_d = (estado_d == SINCRONIZADO);
  end

  assign bus.o_sincronizado = sinc_q;
  assign bus.o_error        = error_q;
  assign bus.o_errores      = errores_q;
  assign bus.o_vueltas      = vueltas_q;
  assign bus.o_estado       = estado_q;

endmodule

// File: tb/tb_verificador_cuenta.sv
// ---------------------------------------------------------------------------
// tb_verificador_cuenta
// Drives two checkers (ANCHO_ERR=8 and ANCHO_ERR=2) with the same count
// stream: directed scenarios followed by a random walk. Outputs are compared
// every cycle against a behavioural model built from the counting rules.
// ---------------------------------------------------------------------------
module tb_verificador_cuenta;

  localparam int ANCHO     = 4;
  localparam int ESTABLE   = 2;
  localparam int N_BLOQUEO = 3;
  localparam int MODULO    = 1 << ANCHO;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [ANCHO-1:0] cuenta = '0;
  logic             hab = 1'b1;

  int n_aserciones = 0;
  int n_fallos     = 0;

  verificador_cuenta_if #(.ANCHO(ANCHO), .ANCHO_ERR(8)) bus_a ();
  verificador_cuenta_if #(.ANCHO(ANCHO), .ANCHO_ERR(2)) bus_b ();

  assign bus_a.i_cuenta    = cuenta;
  assign bus_a.i_habilitar = hab;
  assign bus_b.i_cuenta    = cuenta;
  assign bus_b.i_habilitar = hab;

  verificador_cuenta #(.ANCHO(ANCHO), .ESTABLE(ESTABLE), .N_BLOQUEO(N_BLOQUEO), .ANCHO_ERR(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_a.slave)
  );

  verificador_cuenta #(.ANCHO(ANCHO), .ESTABLE(ESTABLE), .N_BLOQUEO(N_BLOQUEO), .ANCHO_ERR(2)) dut_sat (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_b.slave)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Count reaches the filter two edges after it is presented.
  int retardo[$];
  int m_cand, m_racha, m_ref, m_estado, m_run;
  int m_err_total, m_vuel_total;
  bit m_pulso;

  function automatic int saturar(input int v, input int maximo);
    return (v > maximo) ? maximo : v;
  endfunction

  task automatic comprobar(input string tag, input int obs, input int esp);
    n_aserciones++;
    if (obs != esp) begin
      n_fallos++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, esp);
    end
  endtask

  task automatic modelo_reset();
    retardo = '{0, 0};
    m_cand = 0; m_racha = 0; m_ref = 0; m_estado = 0; m_run = 0;
    m_err_total = 0; m_vuel_total = 0; m_pulso = 0;
  endtask

  // Applies the rules for one clock edge using the inputs present at it.
  task automatic modelo_flanco();
    int  muestra;
    bit  acepta;
    muestra = retardo.pop_front();
    retardo.push_back(int'(cuenta));
    acepta  = 0;
    m_pulso = 0;
    if (!hab) begin
      m_racha = 0;
    end else if (muestra == m_cand) begin
      if (m_racha < ESTABLE) begin
        m_racha++;
        acepta = (m_racha == ESTABLE);
      end
    end else begin
      m_cand  = muestra;
      m_racha = 1;
      acepta  = (ESTABLE == 1);
    end
    if (acepta) begin
      bit igual, correcto;
      igual    = (muestra == m_ref);
      correcto = (muestra == (m_ref + 1) % MODULO);
      if (m_estado == 0) begin
        m_run = 0;
        m_estado = 1;
      end else if (m_estado == 1) begin
        if (correcto) begin
          m_run++;
          if (m_run >= N_BLOQUEO) m_estado = 2;
        end else if (!igual) begin
          m_run = 0;
        end
      end else begin
        if (correcto) begin
          if (muestra == 0) m_vuel_total++;
        end else if (!igual) begin
          m_pulso = 1;
          m_err_total++;
          m_estado = 1;
          m_run = 0;
        end
      end
      m_ref = muestra;
    end
  endtask

  task automatic chequear();
    comprobar("estado",      int'(bus_a.o_estado),       m_estado);
    comprobar("sincronizado", int'(bus_a.o_sincronizado), (m_estado == 2) ? 1 : 0);
    comprobar("error",       int'(bus_a.o_error),        int'(m_pulso));
    comprobar("errores",     int'(bus_a.o_errores),      saturar(m_err_total, 255));
    comprobar("vueltas",     int'(bus_a.o_vueltas),      saturar(m_vuel_total, 255));
    comprobar("estado_sat",  int'(bus_b.o_estado),       m_estado);
    comprobar("errores_sat", int'(bus_b.o_errores),      saturar(m_err_total, 3));
    comprobar("vueltas_sat", int'(bus_b.o_vueltas),      saturar(m_vuel_total, 3));
  endtask

  // One clock: advance model at the rising edge, check at the falling edge.
  task automatic paso();
    @(posedge clk);
    if (rst) modelo_reset();
    else     modelo_flanco();
    @(negedge clk);
    chequear();
  endtask

  task automatic mantener(input int v, input int ciclos);
    cuenta = ANCHO'(v);
    repeat (ciclos) paso();
  endtask

  // Reset asserted between edges: outputs must clear before the next edge.
  task automatic reset_medio();
    #2;
    rst = 1'b1;
    #1;
    modelo_reset();
    comprobar("rst_sinc",    int'(bus_a.o_sincronizado), 0);
    comprobar("rst_error",   int'(bus_a.o_error),        0);
    comprobar("rst_errores", int'(bus_a.o_errores),      0);
    comprobar("rst_vueltas", int'(bus_a.o_vueltas),      0);
    comprobar("rst_estado",  int'(bus_a.o_estado),       0);
    paso();
    rst = 1'b0;
  endtask

  initial begin
    int cur;
    modelo_reset();
    // Reset state
    repeat (3) paso();
    rst = 1'b0;

    // 1: lock on 0..4
    for (int v = 0; v <= 4; v++) mantener(v, 4);
    comprobar("t1_estado", int'(bus_a.o_estado), 2);
    comprobar("t1_errores", int'(bus_a.o_errores), 0);

    // 2: wrap while locked
    for (int v = 5; v <= 15; v++) mantener(v, 4);
    mantener(0, 4);
    mantener(1, 4);
    comprobar("t2_vueltas", int'(bus_a.o_vueltas), 1);
    comprobar("t2_sinc", int'(bus_a.o_sincronizado), 1);

    // 3: error from 5 to 9, relock on 12
    for (int v = 2; v <= 5; v++) mantener(v, 4);
    mantener(9, 4);
    comprobar("t3_errores", int'(bus_a.o_errores), 1);
    comprobar("t3_estado", int'(bus_a.o_estado), 1);
    for (int v = 10; v <= 12; v++) mantener(v, 4);
    comprobar("t3_relock", int'(bus_a.o_estado), 2);

    // 4: one-cycle glitch while locked at 6
    for (int v = 13; v <= 22; v++) mantener(v % MODULO, 4);
    mantener(4, 1);
    mantener(6, 4);
    comprobar("t4_errores", int'(bus_a.o_errores), 1);

    // 5: five locked errors, saturating the narrow counter
    cur = 6;
    for (int k = 0; k < 5; k++) begin
      cur = (cur + 5) % MODULO;
      mantener(cur, 4);
      for (int j = 0; j < N_BLOQUEO; j++) begin
        cur = (cur + 1) % MODULO;
        mantener(cur, 4);
      end
    end
    comprobar("t5_errores_sat", int'(bus_b.o_errores), 3);
    comprobar("t5_errores", int'(bus_a.o_errores), 6);

    // 6: mid-cycle reset, then relock from 7
    for (int k = 0; k < 20; k++) begin
      cur = (cur + 1) % MODULO;
      mantener(cur, 3);
    end
    reset_medio();
    for (int v = 7; v <= 10; v++) mantener(v, 4);
    comprobar("t6_estado", int'(bus_a.o_estado), 2);
    comprobar("t6_vueltas", int'(bus_a.o_vueltas), 0);

    // Random walk: mostly +1, some jumps, glitches and disabled stretches.
    cur = 10;
    for (int s = 0; s < 400; s++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 65) begin
        cur = (cur + 1) % MODULO;
        mantener(cur, $urandom_range(1, 4));
      end else if (r < 75) begin
        cur = $urandom_range(0, MODULO - 1);
        mantener(cur, $urandom_range(1, 4));
      end else if (r < 85) begin
        mantener($urandom_range(0, MODULO - 1), 1);
        mantener(cur, 1);
      end else begin
        hab = 1'b0;
        if ($urandom_range(0, 1) == 1) cur = (cur + 1) % MODULO;
        mantener(cur, $urandom_range(1, 5));
        hab = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_aserciones, n_fallos);
    $finish;
  end

endmodule
